// File: rtl/register_file_2r1w.sv
// Parametrised 2-read/1-write register bank with combinational write-through
// reads and a one-entry-per-cycle clear sweep. Optional macro: REGFILE_ZERO_REG_EN.
module register_file_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] busIn,
  input  logic [ADDR_WIDTH-1:0] rdAddrA,
  input  logic [ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATA_WIDTH-1:0] busOutA,
  output logic [DATA_WIDTH-1:0] busOutB,
  input  logic                  clrStart,
  output logic                  busy,
  output logic                  dbgState
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // Handshake: a write is taken on any rising edge where weff is high; there is
  // no back-pressure beyond busy, which drops (not stalls) requests while high.
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   mem_d [NUM_REGS];
  logic                    weff;

  assign busy     = (state_q == CLEAR);
  assign dbgState = state_q;

`ifdef REGFILE_ZERO_REG_EN
  assign weff = wrEn & ~busy & ~clrStart & (wrAddr != '0);
`else
  assign weff = wrEn & ~busy & ~clrStart;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (clrStart) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (weff) begin
          mem_d[wrAddr] = busIn;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
`ifdef REGFILE_ZERO_REG_EN
    mem_d[0] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    busOutA = (weff && (wrAddr == rdAddrA)) ? busIn : mem_q[rdAddrA];
    busOutB = (weff && (wrAddr == rdAddrB)) ? busIn : mem_q[rdAddrB];
`ifdef REGFILE_ZERO_REG_EN
    if (rdAddrA == '0) busOutA = '0;
    if (rdAddrB == '0) busOutB = '0;
`endif
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Parametrised register file; successor to the single 16-bit register.
- Provides NUM_REGS entries of DATA_WIDTH bits, one synchronous write port and two combinational read ports with same-cycle write-through (pass-through) bypass.
- Adds a multi-cycle sequential clear sweep controlled by a small FSM.
- Sits between the datapath ALU and the lab control unit as the general-purpose register bank.

Parameters:
- DATA_WIDTH, 16, bits per register.
- ADDR_WIDTH, 3, address bits; NUM_REGS = 2**ADDR_WIDTH (derived localparam, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk at the integration level.
- wrEn  input  1  write request.
- wrAddr  input  ADDR_WIDTH  write address.
- busIn  input  DATA_WIDTH  write data.
- rdAddrA  input  ADDR_WIDTH  read port A address.
- rdAddrB  input  ADDR_WIDTH  read port B address.
- busOutA  output  DATA_WIDTH  read port A data (combinational).
- busOutB  output  DATA_WIDTH  read port B data (combinational).
- clrStart  input  1  one-cycle request to start a clear sweep.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (rst=0, asynchronous): all entries=0, FSM=IDLE, sweep pointer=0, busy=0. Outputs then read 0.
- Reset mid-sweep aborts the sweep immediately, with the same result as above.
- Effective write: weff = wrEn & ~busy & ~clrStart. On a clk edge with weff=1, mem[wrAddr] <= busIn. Write latency is 1 cycle.
- Read: busOutX = (weff && wrAddr==rdAddrX) ? busIn : mem[rdAddrX].
  - The bypass is combinational, in the same cycle as the write.
  - Both ports may address the same entry and both may bypass at once.
- FSM states are IDLE and CLEAR.
- IDLE:
  - clrStart=1 -> CLEAR, pointer=0.
  - clrStart has priority over wrEn in the same cycle; that write is dropped and not bypassed.
- CLEAR:
  - Each cycle, mem[pointer] <= 0 and pointer increments.
  - After pointer = NUM_REGS-1 is cleared -> IDLE.
  - busy=1 for exactly NUM_REGS cycles, starting the cycle after clrStart is sampled.
- During CLEAR:
  - wrEn is ignored: no write, no bypass.
  - clrStart is ignored: no restart.
  - Reads return current mem contents, so already-cleared entries read 0 and uncleared entries read their old values.
- busy is a registered output: it goes 0 on the edge that finishes the sweep, so wrEn is accepted again in the following cycle.
- Width rules: no truncation or extension; all buses are exactly DATA_WIDTH and addresses cover exactly NUM_REGS entries.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to 0.
  - Writes to wrAddr=0 are dropped, with no bypass.
  - busOutA/B read 0 whenever the corresponding rdAddr is 0.
  - The sweep still runs for NUM_REGS cycles.
- Undefined: entry 0 is an ordinary register.

Test Plan:
1. Reset/basic write-read: hold rst=0 for 2 cycles, release; write 0xBEEF to addr 5, then read A=5, B=0 -> busOutA=0xBEEF, busOutB=0x0000.
2. Bypass: with mem[3]=0x1111, in one cycle wrEn=1, wrAddr=3, busIn=0x2222, rdAddrA=rdAddrB=3 -> both outputs 0x2222 that cycle; next cycle with wrEn=0 -> both still 0x2222.
3. Clear sweep: fill entries 0..7 with 0x00F0+i, pulse clrStart -> busy=1 for exactly 8 cycles. During the sweep, reading addr 7 gives 0x00F7 until the 8th sweep cycle, then 0. All entries read 0 afterwards.
4. Priority/ignore: clrStart=1 with wrEn=1, wrAddr=2, busIn=0xAAAA -> addr 2 never holds 0xAAAA. A wrEn to addr 4 with 0x5555 during busy is dropped, and addr 4 reads 0 after the sweep.
5. Async reset mid-sweep: assert rst=0 at sweep cycle 3, between clock edges -> busy=0 and all outputs 0 immediately, without waiting for a clk edge.
6. With REGFILE_ZERO_REG_EN: write 0x1234 to addr 0 while rdAddrA=0 -> busOutA=0 in the same cycle and in all later cycles.
